// File: rtl/encrypt_out.sv
// Twofish-128 block encryption core, one Feistel round per clock.
// Round subkeys are regenerated every cycle from the latched key.
module encrypt_out (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plain_text,
  input  logic [127:0] key,
  output logic [127:0] encrypt,
  output logic         done,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [63:0] Q0_T0 = 64'h817D6F320B59ECA4;
  localparam logic [63:0] Q0_T1 = 64'hECB81235F4A6709D;
  localparam logic [63:0] Q0_T2 = 64'hBA5E6D90C8F32471;
  localparam logic [63:0] Q0_T3 = 64'hD7F4126E9B3085CA;
  localparam logic [63:0] Q1_T0 = 64'h28BDF76E31940AC5;
  localparam logic [63:0] Q1_T1 = 64'h1E2B4C376DA5F908;
  localparam logic [63:0] Q1_T2 = 64'h4C75169A0ED82B3F;
  localparam logic [63:0] Q1_T3 = 64'hB951C3DE647F208A;

  localparam logic [255:0] RS_M = {
    64'h01A455875A58DB9E,
    64'hA45682F31EC668E5,
    64'h02A1FCC147AE3D19,
    64'hA455875A58DB9E03
  };

  function automatic logic [3:0] nib(
    input logic [63:0] t,
    input logic [3:0]  i
  );
    return t[{~i, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] qperm(
    input logic       sel,
    input logic [7:0] x
  );
    logic [63:0] t0, t1, t2, t3;
    logic [3:0]  a0, b0, a1, b1, a2, b2;
    logic [3:0]  a3, b3, a4, b4;
    t0 = sel ? Q1_T0 : Q0_T0;
    t1 = sel ? Q1_T1 : Q0_T1;
    t2 = sel ? Q1_T2 : Q0_T2;
    t3 = sel ? Q1_T3 : Q0_T3;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
    a2 = nib(t0, a1);
    b2 = nib(t1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    a4 = nib(t2, a3);
    b4 = nib(t3, b3);
    return {b4, a4};
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] p
  );
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? p : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] mef(input logic [7:0] x);
    return gmul(8'hEF, x, 8'h69);
  endfunction

  function automatic logic [7:0] m5b(input logic [7:0] x);
    return gmul(8'h5B, x, 8'h69);
  endfunction

  function automatic logic [31:0] mds(input logic [31:0] y);
    logic [7:0] y0, y1, y2, y3;
    logic [7:0] z0, z1, z2, z3;
    y0 = y[7:0];
    y1 = y[15:8];
    y2 = y[23:16];
    y3 = y[31:24];
    z0 = y0 ^ mef(y1) ^ m5b(y2) ^ m5b(y3);
    z1 = m5b(y0) ^ mef(y1) ^ mef(y2) ^ y3;
    z2 = mef(y0) ^ m5b(y1) ^ y2 ^ mef(y3);
    z3 = mef(y0) ^ y1 ^ mef(y2) ^ m5b(y3);
    return {z3, z2, z1, z0};
  endfunction

  function automatic logic [31:0] hfun(
    input logic [31:0] x,
    input logic [31:0] l0,
    input logic [31:0] l1
  );
    logic [7:0] y0, y1, y2, y3;
    y0 = qperm(1'b0, x[7:0]) ^ l1[7:0];
    y0 = qperm(1'b1, qperm(1'b0, y0) ^ l0[7:0]);
    y1 = qperm(1'b1, x[15:8]) ^ l1[15:8];
    y1 = qperm(1'b0, qperm(1'b0, y1) ^ l0[15:8]);
    y2 = qperm(1'b0, x[23:16]) ^ l1[23:16];
    y2 = qperm(1'b1, qperm(1'b1, y2) ^ l0[23:16]);
    y3 = qperm(1'b1, x[31:24]) ^ l1[31:24];
    y3 = qperm(1'b0, qperm(1'b1, y3) ^ l0[31:24]);
    return mds({y3, y2, y1, y0});
  endfunction

  // Reed-Solomon fold of eight key bytes into one S-box key word
  function automatic logic [31:0] rs(input logic [63:0] m);
    logic [31:0] s;
    logic [7:0]  acc;
    s = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 8; j++) begin
        acc = acc ^ gmul(RS_M[255 - 8 * (8 * r + j) -: 8],
                         m[63 - 8 * j -: 8], 8'h4D);
      end
      s[8 * r +: 8] = acc;
    end
    return s;
  endfunction

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] rol8(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  // {K(2i), K(2i+1)}
  function automatic logic [63:0] pair(
    input logic [4:0]  idx,
    input logic [31:0] m0,
    input logic [31:0] m1,
    input logic [31:0] m2,
    input logic [31:0] m3
  );
    logic [7:0]  e, o;
    logic [31:0] a, b, s;
    e = {2'b00, idx, 1'b0};
    o = {2'b00, idx, 1'b1};
    a = hfun({4{e}}, m0, m2);
    b = rol8(hfun({4{o}}, m1, m3));
    s = a + {b[30:0], 1'b0};
    return {a + b, {s[22:0], s[31:23]}};
  endfunction

  state_t       state, state_nx;
  logic         load, step, last;
  logic [3:0]   rnd;
  logic [127:0] key_q, key_src;
  logic [31:0]  s0, s1, s0_in, s1_in;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  wk4, wk5, wk6, wk7;
  logic [31:0]  m0, m1, m2, m3;
  logic [31:0]  p0, p1, p2, p3;
  logic [4:0]   idx_a, idx_b;
  logic [63:0]  ka, kb;
  logic [31:0]  t0, t1, f0, f1, n0, n1;
  logic [31:0]  c0, c1, c2, c3;

  assign key_src = (state == IDLE) ? key : key_q;
  assign m0 = bsw(key_src[127:96]);
  assign m1 = bsw(key_src[95:64]);
  assign m2 = bsw(key_src[63:32]);
  assign m3 = bsw(key_src[31:0]);

  assign p0 = bsw(plain_text[127:96]);
  assign p1 = bsw(plain_text[95:64]);
  assign p2 = bsw(plain_text[63:32]);
  assign p3 = bsw(plain_text[31:0]);

  // Idle: K0..K3 for input whitening. Run: round keys on
  // port a, output-whitening keys K4..K7 captured on port b.
  assign idx_a = (state == IDLE) ? 5'd0
               : {1'b0, rnd} + 5'd4;
  assign idx_b = (state == IDLE) ? 5'd1
               : ((rnd == 4'd0) ? 5'd2 : 5'd3);
  assign ka = pair(idx_a, m0, m1, m2, m3);
  assign kb = pair(idx_b, m0, m1, m2, m3);

  assign s0_in = rs(key[127:64]);
  assign s1_in = rs(key[63:0]);

  assign t0 = hfun(w0, s1, s0);
  assign t1 = hfun(rol8(w1), s1, s0);
  assign f0 = t0 + t1 + ka[63:32];
  assign f1 = t0 + {t1[30:0], 1'b0} + ka[31:0];
  assign n0 = {f0[0] ^ w2[0], (w2[31:1] ^ f0[31:1])};
  assign n1 = {w3[30:0], w3[31]} ^ f1;

  assign c0 = w0 ^ wk4;
  assign c1 = w1 ^ wk5;
  assign c2 = n0 ^ wk6;
  assign c3 = n1 ^ wk7;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (rnd == 4'd15) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      encrypt <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      rnd     <= '0;
      key_q   <= '0;
      s0      <= '0;
      s1      <= '0;
      w0      <= '0;
      w1      <= '0;
      w2      <= '0;
      w3      <= '0;
      wk4     <= '0;
      wk5     <= '0;
      wk6     <= '0;
      wk7     <= '0;
    end else begin
      done <= last;
      if (load) begin
        key_q <= key;
        s0    <= s0_in;
        s1    <= s1_in;
        w0    <= p0 ^ ka[63:32];
        w1    <= p1 ^ ka[31:0];
        w2    <= p2 ^ kb[63:32];
        w3    <= p3 ^ kb[31:0];
        busy  <= 1'b1;
        rnd   <= '0;
      end
      if (step) begin
        w0  <= n0;
        w1  <= n1;
        w2  <= w0;
        w3  <= w1;
        rnd <= rnd + 4'd1;
        if (rnd == 4'd0) {wk4, wk5} <= kb;
        if (rnd == 4'd1) {wk6, wk7} <= kb;
      end
      if (last) begin
        encrypt <= {bsw(c0), bsw(c1), bsw(c2), bsw(c3)};
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encrypt_out.sv
// Bench for encrypt_out: known-answer vectors, protocol corners
// and random blocks against a table-driven Twofish model.
module tb_encrypt_out;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] plain_text;
  logic [127:0] key;
  logic [127:0] encrypt;
  logic         done;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] V1 =
    128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
  localparam logic [127:0] V2 =
    128'hD491DB16E7B1C39E86CB086B789F5419;
  localparam logic [127:0] V3 =
    128'h019F9809DE1711858FAAC3A3BA20FBC3;

  always #5 clk = ~clk;

  encrypt_out dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plain_text (plain_text),
    .key        (key),
    .encrypt    (encrypt),
    .done       (done),
    .busy       (busy)
  );

  logic [63:0] tt [2][4];
  logic [7:0]  qt [2][256];
  int          mdsm [4][4];
  int          rsm [4][8];
  int          qa [4];
  int          qb [4];
  int          qc [4];

  function automatic int tnib(input logic [63:0] t, input int i);
    return int'((t >> (60 - 4 * i)) & 64'hF);
  endfunction

  function automatic int ror4(input int v);
    return ((v >> 1) | ((v & 1) << 3)) & 15;
  endfunction

  task automatic build_tables();
    int a, b;
    tt = '{'{64'h817D6F320B59ECA4, 64'hECB81235F4A6709D,
             64'hBA5E6D90C8F32471, 64'hD7F4126E9B3085CA},
           '{64'h28BDF76E31940AC5, 64'h1E2B4C376DA5F908,
             64'h4C75169A0ED82B3F, 64'hB951C3DE647F208A}};
    mdsm = '{'{'h01, 'hEF, 'h5B, 'h5B},
             '{'h5B, 'hEF, 'hEF, 'h01},
             '{'hEF, 'h5B, 'h01, 'hEF},
             '{'hEF, 'h01, 'hEF, 'h5B}};
    rsm = '{'{'h01, 'hA4, 'h55, 'h87, 'h5A, 'h58, 'hDB, 'h9E},
            '{'hA4, 'h56, 'h82, 'hF3, 'h1E, 'hC6, 'h68, 'hE5},
            '{'h02, 'hA1, 'hFC, 'hC1, 'h47, 'hAE, 'h3D, 'h19},
            '{'hA4, 'h55, 'h87, 'h5A, 'h58, 'hDB, 'h9E, 'h03}};
    qa = '{0, 1, 0, 1};
    qb = '{0, 0, 1, 1};
    qc = '{1, 0, 1, 0};
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 256; x++) begin
        a = x >> 4;
        b = x & 15;
        for (int st = 0; st < 2; st++) begin
          int na, nb;
          na = a ^ b;
          nb = (a ^ ror4(b) ^ (8 * a)) & 15;
          a = tnib(tt[s][2 * st], na);
          b = tnib(tt[s][2 * st + 1], nb);
        end
        qt[s][x] = 8'((b << 4) | a);
      end
    end
  endtask

  function automatic int gm(input int a, input int b, input int poly);
    int r = 0;
    while (b != 0) begin
      if ((b & 1) != 0) r = r ^ a;
      a = a << 1;
      if ((a & 256) != 0) a = a ^ poly;
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] h_ref(
    input logic [31:0] x,
    input logic [31:0] l0,
    input logic [31:0] l1
  );
    logic [7:0]  v;
    int          y [4];
    int          z;
    logic [31:0] r;
    for (int j = 0; j < 4; j++) begin
      v = qt[qa[j]][x[8 * j +: 8]];
      v = qt[qb[j]][v ^ l1[8 * j +: 8]];
      v = qt[qc[j]][v ^ l0[8 * j +: 8]];
      y[j] = int'(v);
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      z = 0;
      for (int j = 0; j < 4; j++) z = z ^ gm(mdsm[i][j], y[j], 'h169);
      r[8 * i +: 8] = 8'(z);
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_encrypt(
    input logic [127:0] k,
    input logic [127:0] p
  );
    logic [7:0]   kb [16];
    logic [31:0]  mw [4];
    logic [31:0]  pw [4];
    logic [31:0]  sw [2];
    logic [31:0]  kk [40];
    logic [31:0]  rr [4];
    logic [31:0]  a, b, t0, t1, f0, f1, cw;
    logic [127:0] out;
    int           acc;
    for (int n = 0; n < 16; n++) kb[n] = k[127 - 8 * n -: 8];
    for (int i = 0; i < 4; i++) begin
      mw[i] = '0;
      pw[i] = '0;
      for (int j = 0; j < 4; j++) begin
        mw[i][8 * j +: 8] = kb[4 * i + j];
        pw[i][8 * j +: 8] = p[127 - 8 * (4 * i + j) -: 8];
      end
    end
    for (int i = 0; i < 2; i++) begin
      sw[i] = '0;
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int j = 0; j < 8; j++)
          acc = acc ^ gm(rsm[r][j], int'(kb[8 * i + j]), 'h14D);
        sw[i][8 * r +: 8] = 8'(acc);
      end
    end
    for (int i = 0; i < 20; i++) begin
      a = h_ref(32'(2 * i) * 32'h01010101, mw[0], mw[2]);
      b = rol(h_ref(32'(2 * i + 1) * 32'h01010101, mw[1], mw[3]), 8);
      kk[2 * i]     = a + b;
      kk[2 * i + 1] = rol(a + 2 * b, 9);
    end
    for (int i = 0; i < 4; i++) rr[i] = pw[i] ^ kk[i];
    for (int r = 0; r < 16; r++) begin
      logic [31:0] o0, o1;
      t0 = h_ref(rr[0], sw[1], sw[0]);
      t1 = h_ref(rol(rr[1], 8), sw[1], sw[0]);
      f0 = t0 + t1 + kk[2 * r + 8];
      f1 = t0 + 2 * t1 + kk[2 * r + 9];
      o0 = rr[0];
      o1 = rr[1];
      rr[0] = rol(rr[2] ^ f0, 31);
      rr[1] = rol(rr[3], 1) ^ f1;
      rr[2] = o0;
      rr[3] = o1;
    end
    out = '0;
    for (int i = 0; i < 4; i++) begin
      cw = rr[(i + 2) % 4] ^ kk[i + 4];
      for (int j = 0; j < 4; j++)
        out[127 - 8 * (4 * i + j) -: 8] = cw[8 * j +: 8];
    end
    return out;
  endfunction

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_blk(input logic [127:0] k, input logic [127:0] p);
    key        = k;
    plain_text = p;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // lat counts the start edge as clock 1
  task automatic wait_done(input int budget, output int lat);
    bit got = 0;
    lat = 1;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      lat++;
      if (done) got = 1;
    end
  endtask

  task automatic run_vec(
    input string        tag,
    input logic [127:0] k,
    input logic [127:0] p,
    input logic [127:0] exp
  );
    int lat;
    start_blk(k, p);
    chk_bit({tag, "_busy"}, busy, 1'b1);
    wait_done(30, lat);
    chk_int({tag, "_latency"}, lat, 17);
    chk({tag, "_ct"}, encrypt, exp);
    tick();
    chk_bit({tag, "_done_pulse"}, done, 1'b0);
    chk_bit({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int           lat, nd, dl;
    logic [127:0] res, rk, rp;
    build_tables();
    rst        = 1'b1;
    start      = 1'b0;
    key        = '0;
    plain_text = '0;
    #12;
    chk("reset_encrypt", encrypt, '0);
    chk_bit("reset_done", done, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    run_vec("vec1", '0, '0, V1);
    run_vec("vec2", '0, V1, V2);
    run_vec("vec3", V1, V2, V3);

    // start while busy, inputs scrambled after the start edge
    start_blk('0, '0);
    lat = 1;
    nd  = 0;
    dl  = 0;
    res = '0;
    for (int i = 0; i < 35; i++) begin
      if (i < 6) begin
        key        = {$urandom, $urandom, $urandom, $urandom};
        plain_text = {$urandom, $urandom, $urandom, $urandom};
      end
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      tick();
      lat++;
      if (i == 4) chk_bit("ignored_start_busy", busy, 1'b1);
      if (done) begin
        nd++;
        if (nd == 1) begin
          dl  = lat;
          res = encrypt;
        end
      end
    end
    chk_int("ignored_start_dones", nd, 1);
    chk_int("ignored_start_latency", dl, 17);
    chk("ignored_start_ct", res, V1);

    // back-to-back: next start lands in the done cycle
    start_blk('0, '0);
    wait_done(30, lat);
    chk("b2b_first_ct", encrypt, V1);
    start_blk('0, V1);
    lat = 1;
    nd  = 0;
    for (int i = 0; i < 30 && nd == 0; i++) begin
      tick();
      lat++;
      if (done) nd = 1;
      else chk($sformatf("b2b_hold_%0d", lat), encrypt, V1);
    end
    chk_int("b2b_latency", lat, 17);
    chk("b2b_second_ct", encrypt, V2);

    // asynchronous abort mid-block
    start_blk(V1, V2);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_encrypt", encrypt, '0);
    chk_bit("abort_done", done, 1'b0);
    chk_bit("abort_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    nd  = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) nd++;
    end
    chk_int("abort_no_done", nd, 0);
    chk_bit("abort_still_idle", busy, 1'b0);

    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run_vec($sformatf("rand%0d", n), rk, rp, ref_encrypt(rk, rp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
